vram_arbiter: RTL and testbench

//  Shares one synchronous single-port video RAM between the raster fetch
//  (driven by hvsync_generator hpos/vpos/display_on) and a CPU-side

---
 rtl/vram_arbiter.sv | 86 ++++++++
 tb/tb_vram_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed tile/attribute fetch slots per 8-pixel cell
// for the raster, with the CPU taking every other free cycle via req/ack.
module vram_arbiter #(
    parameter int unsigned       ADDR_W    = 11,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [2:0]        TILE_SLOT = 3'd0,
    parameter logic [2:0]        ATTR_SLOT = 3'd4,
    parameter logic [ADDR_W-1:0] ATTR_BASE = 'h400
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [8:0]        hpos,
    input  logic [8:0]        vpos,
    input  logic              display_on,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] tile_data,
    output logic [DATA_W-1:0] attr_data,
    output logic              tile_valid,
    output logic              attr_valid
);

    typedef enum logic [2:0] {IDLE, VID_TILE, VID_ATTR, CPU_RD, CPU_WR} issue_t;

    issue_t            issued, issued_nxt;
    logic              tile_hit, attr_hit, cpu_busy, we_req;
    logic [ADDR_W-1:0] tile_addr, attr_addr;
    logic              unused_pos_msb;

    // The 256-pixel fetch window only uses position bits [7:0].
    assign unused_pos_msb = &{1'b0, hpos[8], vpos[8]};

    assign tile_hit  = display_on && (hpos[2:0] == TILE_SLOT);
    assign attr_hit  = display_on && (hpos[2:0] == ATTR_SLOT);
    assign cpu_busy  = (issued == CPU_RD) || (issued == CPU_WR);
    assign tile_addr = ADDR_W'({vpos[7:3], hpos[7:3]});
    assign attr_addr = ATTR_BASE + ADDR_W'({vpos[7:5], hpos[7:5]});

    always_comb begin
        issued_nxt = IDLE;
        ram_addr   = '0;
        we_req     = 1'b0;
        if (tile_hit) begin
            ram_addr   = tile_addr;
            issued_nxt = VID_TILE;
        end else if (attr_hit) begin
            ram_addr   = attr_addr;
            issued_nxt = VID_ATTR;
        end else if (cpu_req && !cpu_busy) begin
            // Never issue in an ack cycle, so a held req is not serviced twice.
            ram_addr   = cpu_addr;
            we_req     = cpu_we;
            issued_nxt = cpu_we ? CPU_WR : CPU_RD;
        end
    end

    assign ram_we    = we_req & reset_n;
    assign ram_wdata = cpu_wdata;
    assign cpu_ack   = cpu_busy;
    assign cpu_rdata = ram_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued     <= IDLE;
            tile_data  <= '0;
            attr_data  <= '0;
            tile_valid <= 1'b0;
            attr_valid <= 1'b0;
        end else begin
            issued     <= issued_nxt;
            tile_valid <= (issued == VID_TILE);
            attr_valid <= (issued == VID_ATTR);
            if (issued == VID_TILE) tile_data <= ram_rdata;
            if (issued == VID_ATTR) attr_data <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous VRAM.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  hpos, vpos;
    logic        display_on, cpu_req, cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  tile_data, attr_data;
    logic        tile_valid, attr_valid;

    logic        ld_en;
    logic [10:0] ld_addr;
    logic [7:0]  ld_data;
    logic [7:0]  mem [0:2047];

    int errors = 0;
    int checks = 0;

    vram_arbiter dut (
        .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .tile_data(tile_data),
        .attr_data(attr_data), .tile_valid(tile_valid), .attr_valid(attr_valid)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read data one cycle after the address.
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [10:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 8'hEE;
        #1;
        checks++; if (ram_we !== 1'b0)     begin errors++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        checks++; if (cpu_ack !== 1'b0)    begin errors++; $display("FAIL reset_ack: got %b expected 0", cpu_ack); end
        checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL reset_tile_valid: got %b expected 0", tile_valid); end
        checks++; if (attr_valid !== 1'b0) begin errors++; $display("FAIL reset_attr_valid: got %b expected 0", attr_valid); end
        checks++; if (tile_data !== 8'h00) begin errors++; $display("FAIL reset_tile_data: got 0x%0h expected 0x00", tile_data); end
        checks++; if (attr_data !== 8'h00) begin errors++; $display("FAIL reset_attr_data: got 0x%0h expected 0x00", attr_data); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_blank_read();
        display_on = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
        #1;
        checks++; if (ram_addr !== 11'h123) begin errors++; $display("FAIL blank_addr: got 0x%0h expected 0x123", ram_addr); end
        checks++; if (ram_we !== 1'b0)      begin errors++; $display("FAIL blank_we: got %b expected 0", ram_we); end
        tick();
        checks++; if (cpu_ack !== 1'b1)     begin errors++; $display("FAIL blank_ack: got %b expected 1", cpu_ack); end
        checks++; if (cpu_rdata !== 8'h5A)  begin errors++; $display("FAIL blank_rdata: got 0x%0h expected 0x5a", cpu_rdata); end
        checks++; if (ram_addr !== 11'h000) begin errors++; $display("FAIL blank_ack_no_issue: got 0x%0h expected 0x000", ram_addr); end
        cpu_req = 1'b0;
        tick();
        checks++; if (cpu_ack !== 1'b0)     begin errors++; $display("FAIL blank_ack_drop: got %b expected 0", cpu_ack); end
    endtask

    task automatic test_tile_fetch();
        display_on = 1'b1; hpos = 9'h028; vpos = 9'h010;
        #1;
        checks++; if (ram_addr !== 11'h045) begin errors++; $display("FAIL tile_addr: got 0x%0h expected 0x045", ram_addr); end
        tick();
        hpos = 9'h029;
        #1;
        checks++; if (tile_valid !== 1'b0)  begin errors++; $display("FAIL tile_valid_early: got %b expected 0", tile_valid); end
        tick();
        checks++; if (tile_valid !== 1'b1)  begin errors++; $display("FAIL tile_valid: got %b expected 1", tile_valid); end
        checks++; if (tile_data !== 8'hC3)  begin errors++; $display("FAIL tile_data: got 0x%0h expected 0xc3", tile_data); end
        hpos = 9'h02A;
        tick();
        checks++; if (tile_valid !== 1'b0)  begin errors++; $display("FAIL tile_valid_pulse: got %b expected 0", tile_valid); end
    endtask

    task automatic test_attr_fetch();
        // vpos[7:5]=1, hpos[7:5]=1 -> 0x400 + 6'b001_001
        display_on = 1'b1; hpos = 9'h024; vpos = 9'h030;
        #1;
        checks++; if (ram_addr !== 11'h409) begin errors++; $display("FAIL attr_addr: got 0x%0h expected 0x409", ram_addr); end
        tick();
        hpos = 9'h025;
        tick();
        checks++; if (attr_valid !== 1'b1)  begin errors++; $display("FAIL attr_valid: got %b expected 1", attr_valid); end
        checks++; if (attr_data !== 8'h3C)  begin errors++; $display("FAIL attr_data: got 0x%0h expected 0x3c", attr_data); end
        checks++; if (tile_data !== 8'hC3)  begin errors++; $display("FAIL attr_tile_hold: got 0x%0h expected 0xc3", tile_data); end
        // Bit 8 ignored: hpos=0x104, vpos=0x100 -> base + 0
        hpos = 9'h104; vpos = 9'h100;
        #1;
        checks++; if (ram_addr !== 11'h400) begin errors++; $display("FAIL attr_addr_msb: got 0x%0h expected 0x400", ram_addr); end
        tick();
        hpos = 9'h105;
        tick();
    endtask

    task automatic test_collision();
        display_on = 1'b1; hpos = 9'h030; vpos = 9'h000;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h200; cpu_wdata = 8'h77;
        #1;
        checks++; if (ram_addr !== 11'h006) begin errors++; $display("FAIL coll_video_addr: got 0x%0h expected 0x006", ram_addr); end
        checks++; if (ram_we !== 1'b0)      begin errors++; $display("FAIL coll_video_we: got %b expected 0", ram_we); end
        tick();
        hpos = 9'h031;
        #1;
        checks++; if (ram_addr !== 11'h200) begin errors++; $display("FAIL coll_cpu_addr: got 0x%0h expected 0x200", ram_addr); end
        checks++; if (ram_we !== 1'b1)      begin errors++; $display("FAIL coll_cpu_we: got %b expected 1", ram_we); end
        checks++; if (cpu_ack !== 1'b0)     begin errors++; $display("FAIL coll_ack_early: got %b expected 0", cpu_ack); end
        tick();
        hpos = 9'h032;
        #1;
        checks++; if (cpu_ack !== 1'b1)     begin errors++; $display("FAIL coll_ack: got %b expected 1", cpu_ack); end
        checks++; if (ram_we !== 1'b0)      begin errors++; $display("FAIL coll_ack_we: got %b expected 0", ram_we); end
        checks++; if (mem[11'h200] !== 8'h77) begin errors++; $display("FAIL coll_mem: got 0x%0h expected 0x77", mem[11'h200]); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic prev = 1'b0;
        display_on = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (cpu_ack !== ((i % 2) == 1)) begin
                errors++; $display("FAIL b2b_ack[%0d]: got %b expected %b", i, cpu_ack, (i % 2) == 1);
            end
            checks++;
            if (prev && cpu_ack) begin
                errors++; $display("FAIL b2b_consecutive[%0d]: got ack twice expected once", i);
            end
            prev = cpu_ack;
            tick();
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_write();
        display_on = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h055; cpu_wdata = 8'hAB;
        #1;
        checks++; if (ram_we !== 1'b1)      begin errors++; $display("FAIL rstwr_we_pre: got %b expected 1", ram_we); end
        reset_n = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0)      begin errors++; $display("FAIL rstwr_we_forced: got %b expected 0", ram_we); end
        tick();
        checks++; if (cpu_ack !== 1'b0)     begin errors++; $display("FAIL rstwr_no_ack: got %b expected 0", cpu_ack); end
        checks++; if (mem[11'h055] !== 8'h00) begin errors++; $display("FAIL rstwr_no_write: got 0x%0h expected 0x00", mem[11'h055]); end
        reset_n = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b1)      begin errors++; $display("FAIL rstwr_reissue_we: got %b expected 1", ram_we); end
        checks++; if (ram_addr !== 11'h055) begin errors++; $display("FAIL rstwr_reissue_addr: got 0x%0h expected 0x055", ram_addr); end
        tick();
        checks++; if (cpu_ack !== 1'b1)     begin errors++; $display("FAIL rstwr_ack: got %b expected 1", cpu_ack); end
        checks++; if (mem[11'h055] !== 8'hAB) begin errors++; $display("FAIL rstwr_mem: got 0x%0h expected 0xab", mem[11'h055]); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0; hpos = '0; vpos = '0; display_on = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        preload(11'h000, 8'h00);
        preload(11'h123, 8'h5A);
        preload(11'h045, 8'hC3);
        preload(11'h409, 8'h3C);
        preload(11'h400, 8'h11);
        preload(11'h006, 8'h99);
        preload(11'h200, 8'h00);
        preload(11'h055, 8'h00);
        test_reset();
        test_blank_read();
        test_tile_fetch();
        test_attr_fetch();
        test_collision();
        test_back_to_back();
        test_reset_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
